// File: rtl/dram_pkg.sv
// Shared types for the DRAM bank model: command/state enums, error codes,
// the read-pipeline slot and a small helper for sizing timers.
package dram_pkg;

   localparam int NUM_BANKS = 16;

   typedef enum logic [2:0] {
      CMD_ACT = 3'd0,
      CMD_PRE = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_REF = 3'd4
   } e_dram_cmd_type;

   typedef enum logic [1:0] {
      BANK_IDLE,
      BANK_ACTIVATING,
      BANK_ACTIVE,
      BANK_PRECHARGING
   } e_bank_state;

   localparam logic [2:0] ERR_NONE         = 3'd0;
   localparam logic [2:0] ERR_ACT_NOT_IDLE = 3'd1;
   localparam logic [2:0] ERR_NOT_OPEN     = 3'd2;
   localparam logic [2:0] ERR_BANK_BUSY    = 3'd3;
   localparam logic [2:0] ERR_REF_NOT_IDLE = 3'd4;
   localparam logic [2:0] ERR_REFRESHING   = 3'd5;

   typedef struct packed {
      logic        valid;
      logic [1:0]  bg;
      logic [1:0]  bank;
      logic [15:0] row;
      logic [9:0]  col;
   } rd_slot_t;

   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/dram_bank_fsm.sv
// One DRAM bank: IDLE/ACTIVATING/ACTIVE/PRECHARGING with a saturating timer
// and an open-row register. Only legal act/pre strobes reach this block.
module dram_bank_fsm
   import dram_pkg::*;
#(
   parameter int T_RCD = 24,
   parameter int T_RP  = 24,
   parameter int TW    = 9
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        act,
   input  logic        pre,
   input  logic [15:0] act_row,
   output e_bank_state state,
   output logic [15:0] open_row
);

   e_bank_state    state_next;
   logic [TW-1:0]  timer;
   logic [TW-1:0]  timer_next;
   logic [15:0]    row_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= BANK_IDLE;
         timer    <= '0;
         open_row <= '0;
      end else begin
         state    <= state_next;
         timer    <= timer_next;
         open_row <= row_next;
      end
   end

   // The timer is loaded with delay-1 so the new state is visible exactly
   // delay cycles after the command; a delay of 1 skips the transient state.
   always_comb begin
      state_next = state;
      timer_next = (timer != '0) ? timer - 1'b1 : '0;
      row_next   = open_row;
      case (state)
         BANK_IDLE: begin
            if (act) begin
               row_next = act_row;
               if (T_RCD == 1) begin
                  state_next = BANK_ACTIVE;
               end else begin
                  state_next = BANK_ACTIVATING;
                  timer_next = TW'(T_RCD - 1);
               end
            end
         end
         BANK_ACTIVATING: begin
            if (timer <= TW'(1)) state_next = BANK_ACTIVE;
         end
         BANK_ACTIVE: begin
            if (pre) begin
               if (T_RP == 1) begin
                  state_next = BANK_IDLE;
               end else begin
                  state_next = BANK_PRECHARGING;
                  timer_next = TW'(T_RP - 1);
               end
            end
         end
         BANK_PRECHARGING: begin
            if (timer <= TW'(1)) state_next = BANK_IDLE;
         end
         default: state_next = BANK_IDLE;
      endcase
   end

endmodule

// File: rtl/dram_bank_model.sv
// Cycle-level model of a 16-bank DRAM device: command checking, read return
// pipeline and refresh. Optional counters are enabled by DRAM_BANK_MODEL_CNT_EN.
module dram_bank_model
   import dram_pkg::*;
#(
   parameter int T_RCD = 24,
   parameter int T_RP  = 24,
   parameter int T_CL  = 24,
   parameter int T_RFC = 350
)
(
   input  logic           dram_clk,
   input  logic           reset_n,
   input  logic           cmd_valid,
   input  e_dram_cmd_type dram_cmd,
   input  logic [1:0]     bank_group,
   input  logic [1:0]     bank,
   input  logic [15:0]    row,
   input  logic [9:0]     column,
   output logic           cmd_err,
   output logic [2:0]     err_code,
   output logic           rd_valid,
   output logic [1:0]     rd_bg,
   output logic [1:0]     rd_bank,
   output logic [15:0]    rd_row,
   output logic [9:0]     rd_col,
   output logic           refreshing,
   output logic [31:0]    act_count,
   output logic [31:0]    rd_count,
   output logic [31:0]    wr_count
);

   localparam int TW = $clog2(max_of4(T_RCD, T_RP, T_CL, T_RFC) + 1);

   logic [3:0]           bank_idx;
   e_bank_state          bank_state [NUM_BANKS];
   logic [15:0]          open_row   [NUM_BANKS];
   logic [NUM_BANKS-1:0] act_sel;
   logic [NUM_BANKS-1:0] pre_sel;
   e_bank_state          tgt_state;
   logic                 all_idle;
   logic [2:0]           err;
   logic                 legal;
   logic [TW-1:0]        ref_timer;
   rd_slot_t             rd_new;
   rd_slot_t             rd_pipe [T_CL];

   assign bank_idx   = {bank_group, bank};
   assign tgt_state  = bank_state[bank_idx];
   assign refreshing = (ref_timer != '0);
   assign legal      = cmd_valid && (err == ERR_NONE);

   always_comb begin
      all_idle = 1'b1;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (bank_state[i] != BANK_IDLE) all_idle = 1'b0;
      end
   end

   // Checks are ordered so the highest-priority reason wins on collisions.
   always_comb begin
      err = ERR_NONE;
      if (cmd_valid) begin
         if (refreshing) begin
            err = ERR_REFRESHING;
         end else if (dram_cmd == CMD_REF) begin
            if (!all_idle) err = ERR_REF_NOT_IDLE;
         end else if ((tgt_state == BANK_ACTIVATING) ||
                      ((dram_cmd == CMD_PRE) && (tgt_state == BANK_PRECHARGING))) begin
            err = ERR_BANK_BUSY;
         end else if (((dram_cmd == CMD_RD) || (dram_cmd == CMD_WR)) &&
                      ((tgt_state == BANK_IDLE) || (tgt_state == BANK_PRECHARGING))) begin
            err = ERR_NOT_OPEN;
         end else if ((dram_cmd == CMD_ACT) && (tgt_state != BANK_IDLE)) begin
            err = ERR_ACT_NOT_IDLE;
         end
      end
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      assign act_sel[g] = legal && (dram_cmd == CMD_ACT) && (bank_idx == 4'(g));
      assign pre_sel[g] = legal && (dram_cmd == CMD_PRE) && (bank_idx == 4'(g));

      dram_bank_fsm #(
         .T_RCD (T_RCD),
         .T_RP  (T_RP),
         .TW    (TW)
      ) u_fsm (
         .clk      (dram_clk),
         .rst_n    (reset_n),
         .act      (act_sel[g]),
         .pre      (pre_sel[g]),
         .act_row  (row),
         .state    (bank_state[g]),
         .open_row (open_row[g])
      );
   end

   always_ff @(posedge dram_clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_err   <= 1'b0;
         err_code  <= ERR_NONE;
         ref_timer <= '0;
      end else begin
         cmd_err  <= (err != ERR_NONE);
         err_code <= err;
         if (legal && (dram_cmd == CMD_REF)) begin
            ref_timer <= TW'(T_RFC - 1);
         end else if (ref_timer != '0) begin
            ref_timer <= ref_timer - 1'b1;
         end
      end
   end

   // Fixed-latency shift register keeps back-to-back reads in order.
   assign rd_new = '{valid: legal && (dram_cmd == CMD_RD),
                     bg:    bank_group,
                     bank:  bank,
                     row:   open_row[bank_idx],
                     col:   column};

   always_ff @(posedge dram_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < T_CL; i++) rd_pipe[i] <= '0;
      end else begin
         rd_pipe[0] <= rd_new;
         for (int i = 1; i < T_CL; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   assign rd_valid = rd_pipe[T_CL-1].valid;
   assign rd_bg    = rd_pipe[T_CL-1].bg;
   assign rd_bank  = rd_pipe[T_CL-1].bank;
   assign rd_row   = rd_pipe[T_CL-1].row;
   assign rd_col   = rd_pipe[T_CL-1].col;

`ifdef DRAM_BANK_MODEL_CNT_EN
   always_ff @(posedge dram_clk or negedge reset_n) begin
      if (!reset_n) begin
         act_count <= '0;
         rd_count  <= '0;
         wr_count  <= '0;
      end else if (legal) begin
         case (dram_cmd)
            CMD_ACT: act_count <= act_count + 32'd1;
            CMD_RD:  rd_count  <= rd_count + 32'd1;
            CMD_WR:  wr_count  <= wr_count + 32'd1;
            default: ;
         endcase
      end
   end
`else
   assign act_count = '0;
   assign rd_count  = '0;
   assign wr_count  = '0;
`endif

endmodule

// File: doc/dram_bank_model.md
DRAM_BANK_MODEL -- requirements
Module: dram_bank_model

Interface
REQ-001 Parameters SHALL be (name, default, meaning): T_RCD, 24, ACT-to-RD/WR delay in cycles; T_RP, 24, PRE-to-idle delay; T_CL, 24, RD-to-data delay; T_RFC, 350, refresh busy time; all >= 1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  dram_clk  in  1  sole clock, rising edge;
  reset_n  in  1  asynchronous, active-low reset;
  cmd_valid  in  1  command present this cycle;
  dram_cmd  in  e_dram_cmd_type  ACT/PRE/RD/WR/REF;
  bank_group  in  2  target bank group;
  bank  in  2  target bank within group;
  row  in  16  row address, used by ACT only;
  column  in  10  column address, used by RD/WR;
  cmd_err  out  1  accepted command was illegal, one-cycle pulse;
  err_code  out  3  error reason, valid with cmd_err;
  rd_valid  out  1  read data slot;
  rd_bg, rd_bank  out  2 each  bank of returning read;
  rd_row  out  16  open row of returning read;
  rd_col  out  10  column of returning read;
  refreshing  out  1  refresh in progress;
  act_count, rd_count, wr_count  out  32 each  command counters.

Function
REQ-003 Every cmd_valid cycle SHALL accept exactly one command; there is no back-pressure.
REQ-004 Each of the 16 banks (index = {bank_group,bank}) SHALL run FSM IDLE, ACTIVATING, ACTIVE, PRECHARGING, holding an open-row register.
REQ-005 ACT accepted in cycle N to an IDLE bank SHALL latch row, enter ACTIVATING, and the bank SHALL be ACTIVE from cycle N+T_RCD.
REQ-006 PRE accepted in cycle M to an ACTIVE bank SHALL enter PRECHARGING; the bank SHALL be IDLE from cycle M+T_RP; PRE to an IDLE bank SHALL be a legal no-op.
REQ-007 RD/WR SHALL be legal only to an ACTIVE bank and SHALL not change bank state.
REQ-008 A legal RD accepted in cycle N SHALL produce rd_valid=1 in cycle N+T_CL with rd_bg/rd_bank/rd_row/rd_col of that RD; back-to-back RDs SHALL return back-to-back, in order.
REQ-009 REF in cycle K SHALL be legal only if all 16 banks are IDLE; refreshing SHALL be 1 in cycles K+1 .. K+T_RFC-1 and 0 from K+T_RFC.
REQ-010 Errors SHALL pulse cmd_err in cycle N+1 with err_code: 1 ACT to non-IDLE bank, 2 RD/WR to IDLE or PRECHARGING bank, 3 any command to ACTIVATING bank, or PRE to PRECHARGING bank, 4 REF with any bank non-IDLE, 5 any command while refreshing=1; on collisions, code 5 SHALL take priority, then 4, 3, 2, 1.
REQ-011 An erroneous command SHALL have no effect on bank state, read pipeline or counters.
REQ-012 A command SHALL be checked against the state already updated by a timer expiring at that same edge; e.g. RD in cycle N+T_RCD after ACT in N is legal.
REQ-013 Timers SHALL be sized to $clog2(max parameter + 1) bits and SHALL saturate at zero.

Reset
REQ-014 reset_n low SHALL asynchronously force all banks IDLE, open rows 0, timers 0, read pipeline empty, and all outputs 0.
REQ-015 A reset asserted mid-ACT, mid-refresh, or with reads in flight SHALL discard them; no rd_valid SHALL appear after release for pre-reset RDs.

Configuration
REQ-016 With DRAM_BANK_MODEL_CNT_EN defined, act_count/rd_count/wr_count SHALL increment, wrapping at 2^32, on each legal ACT/RD/WR; without it, they SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-017 Package dram_pkg SHALL hold e_dram_cmd_type, e_bank_state, the error-code constants, and NUM_BANKS=16.
REQ-018 The per-bank FSM and timer SHALL be sub-module dram_bank_fsm, instantiated 16 times; the read pipeline and refresh logic SHALL remain in the top.

Verification (T_RCD=3, T_RP=3, T_CL=4, T_RFC=8)
REQ-019 ACT bg1 b2 row 0x1234 at cycle 10, RD col 0x05 at cycle 13 -> rd_valid at cycle 17 with rd_bg=1, rd_bank=2, rd_row=0x1234, rd_col=0x05, and cmd_err=0 throughout.
REQ-020 ACT bank 0 at cycle 10, RD bank 0 at cycle 12 -> cmd_err=1 with err_code=3 in cycle 13, and no rd_valid.
REQ-021 All banks idle, REF at cycle 20, ACT at cycle 24 -> cmd_err=1 with err_code=5; ACT at cycle 28 -> legal.
REQ-022 Bank 5 ACTIVE, REF -> err_code=4; then PRE bank 5 at cycle M, and REF at cycle M+3 -> legal.
REQ-023 Four RDs at cycles 30-33 with reset_n low at cycle 32 -> no rd_valid after release, all banks IDLE, counters 0.
REQ-024 With DRAM_BANK_MODEL_CNT_EN defined, 3 legal ACT, 5 RD, 2 WR and 1 illegal RD -> act_count=3, rd_count=5, wr_count=2; without the macro, all counters stay 0.
